// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared types and helpers for the button pulse conditioner.
//   btn_state_t : per-channel press/auto-repeat FSM states
//   max_u       : larger of two unsigned values
//   width_for   : bits needed to hold 0..n-1, never less than one bit
// -----------------------------------------------------------------------------
package button_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE,    // released, waiting for a debounced press
    BTN_HOLD,    // pressed, counting towards the first repeat
    BTN_REPEAT,  // pressed, emitting periodic repeat pulses
    BTN_HELD     // pressed with auto-repeat disabled, waiting for release
  } btn_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned width_for(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_pulse_conditioner_channel.sv
// -----------------------------------------------------------------------------
// button_channel
// One independent button path: 2-FF synchroniser, debounce filter and the
// press / auto-repeat pulse FSM.
// Ports:
//   clk       in  system clock, all state on the rising edge
//   reset_n   in  asynchronous active-low reset
//   btn_raw   in  raw pin, asynchronous, polarity set by ACTIVE_LOW_IN
//   btn_level out debounced level, 1 = pressed
//   btn_pulse out registered one-cycle pulse on press and on each repeat
// -----------------------------------------------------------------------------
module button_channel
  import button_pkg::*;
#(
  parameter bit          ACTIVE_LOW_IN   = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter int unsigned HOLD_CYCLES     = 10,
  parameter int unsigned REPEAT_CYCLES   = 5
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse
);

  localparam int unsigned CNT_W = width_for(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TMR_W = width_for(max_u(HOLD_CYCLES, REPEAT_CYCLES));

  localparam logic             RELEASED_RAW = ACTIVE_LOW_IN ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST    = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] REPEAT_LAST  = TMR_W'(REPEAT_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             w_pressed;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  btn_state_t       r_state;
  btn_state_t       w_state_nxt;
  logic [TMR_W-1:0] r_tmr;
  logic [TMR_W-1:0] w_tmr_nxt;
  logic             r_pulse;
  logic             w_pulse_nxt;

  // NOTE: the synchroniser resets to the released pin level, not to 0, so a
  // button held through reset still has to pass the full debounce afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= RELEASED_RAW;
      r_sync2 <= RELEASED_RAW;
    end else begin
      // NOTE: non-blocking assignments make r_sync2 take the old r_sync1,
      // giving two real flop stages rather than one.
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Polarity normalised after the synchroniser: 1 = pressed.
  assign w_pressed = r_sync2 ^ RELEASED_RAW;

  // A level change is accepted on the DEBOUNCE_CYCLES-th consecutive sample
  // that differs from the current level; any agreeing sample restarts the run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (w_pressed == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_level <= w_pressed;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= BTN_IDLE;
      r_tmr   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  // The timer is cleared on every state entry and only counts up to the
  // current state's terminal value, so it can never wrap.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr + 1'b1;
    w_pulse_nxt = 1'b0;
    case (r_state)
      BTN_IDLE: begin
        w_tmr_nxt = '0;
        if (r_level) begin
          w_pulse_nxt = 1'b1;
          w_state_nxt = REPEAT_EN ? BTN_HOLD : BTN_HELD;
        end
      end
      BTN_HOLD: begin
        // Release wins over a coinciding timer expiry: release never pulses.
        if (!r_level) begin
          w_state_nxt = BTN_IDLE;
          w_tmr_nxt   = '0;
        end else if (r_tmr == HOLD_LAST) begin
          w_pulse_nxt = 1'b1;
          w_tmr_nxt   = '0;
          w_state_nxt = BTN_REPEAT;
        end
      end
      BTN_REPEAT: begin
        if (!r_level) begin
          w_state_nxt = BTN_IDLE;
          w_tmr_nxt   = '0;
        end else if (r_tmr == REPEAT_LAST) begin
          w_pulse_nxt = 1'b1;
          w_tmr_nxt   = '0;
        end
      end
      BTN_HELD: begin
        w_tmr_nxt = '0;
        if (!r_level) begin
          w_state_nxt = BTN_IDLE;
        end
      end
      default: begin
        w_state_nxt = BTN_IDLE;
        w_tmr_nxt   = '0;
      end
    endcase
  end

  assign btn_level = r_level;
  assign btn_pulse = r_pulse;

endmodule

// File: rtl/button_pulse_conditioner.sv
// -----------------------------------------------------------------------------
// button_pulse_conditioner
// Turns raw, bouncy push-buttons into clean debounced levels and one-clock move
// pulses (press plus optional hold auto-repeat). Channels are fully independent;
// any arbitration between buttons belongs to the consumer.
// Ports:
//   clk       in  system clock
//   reset_n   in  asynchronous active-low reset
//   btn_raw   in  [NUM_BTN] raw pins, polarity set by ACTIVE_LOW_IN
//   btn_level out [NUM_BTN] debounced level, 1 = pressed
//   btn_pulse out [NUM_BTN] one-cycle pulse per accepted press / repeat
// -----------------------------------------------------------------------------
module button_pulse_conditioner
  import button_pkg::*;
#(
  parameter int unsigned NUM_BTN         = 2,
  parameter bit          ACTIVE_LOW_IN   = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter int unsigned HOLD_CYCLES     = 10,
  parameter int unsigned REPEAT_CYCLES   = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse
);

  for (genvar g = 0; g < int'(NUM_BTN); g++) begin : g_chan
    button_channel #(
      .ACTIVE_LOW_IN  (ACTIVE_LOW_IN),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_EN      (REPEAT_EN),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_chan (
      .clk      (clk),
      .reset_n  (reset_n),
      .btn_raw  (btn_raw[g]),
      .btn_level(btn_level[g]),
      .btn_pulse(btn_pulse[g])
    );
  end

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_pulse_conditioner
// Drives two conditioners from the same pins: one with auto-repeat, one
// single-shot. A behavioural model (sample age, run length of differing
// samples, time since press) predicts level and pulse every cycle; directed
// scenarios additionally pin pulse timing to hand-computed edge numbers.
// Edge numbering: the first rising edge after the stimulus is applied is edge 1.
// -----------------------------------------------------------------------------
module tb_button_pulse_conditioner;

  localparam int D = 4;
  localparam int H = 10;
  localparam int R = 5;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b1;
  logic [1:0] btn_raw = 2'b11;
  logic [1:0] level_one, pulse_one, level_rep, pulse_rep;

  always #5 clk = ~clk;

  button_pulse_conditioner #(
    .NUM_BTN(2), .ACTIVE_LOW_IN(1'b1), .DEBOUNCE_CYCLES(D),
    .REPEAT_EN(1'b0), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
  ) u_dut_one (
    .clk(clk), .reset_n(reset_n), .btn_raw(btn_raw),
    .btn_level(level_one), .btn_pulse(pulse_one)
  );

  button_pulse_conditioner #(
    .NUM_BTN(2), .ACTIVE_LOW_IN(1'b1), .DEBOUNCE_CYCLES(D),
    .REPEAT_EN(1'b1), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
  ) u_dut_rep (
    .clk(clk), .reset_n(reset_n), .btn_raw(btn_raw),
    .btn_level(level_rep), .btn_pulse(pulse_rep)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- behavioural model -----------------------------------------
  // Index [v][c]: v=0 single-shot instance, v=1 auto-repeat instance.
  // m_new/m_old: pressed value seen one / two edges ago (the pin reaches the
  // filter two edges late). m_run: consecutive samples disagreeing with the
  // level. m_age: edges the accepted press has lasted (0 on the accepting edge).
  bit m_new   [2][2] = '{default: 0};
  bit m_old   [2][2] = '{default: 0};
  bit m_level [2][2] = '{default: 0};
  bit m_pulse [2][2] = '{default: 0};
  int m_run   [2][2] = '{default: 0};
  int m_age   [2][2] = '{default: 0};

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int v = 0; v < 2; v++)
        for (int c = 0; c < 2; c++) begin
          m_new[v][c] = 0; m_old[v][c] = 0; m_level[v][c] = 0;
          m_pulse[v][c] = 0; m_run[v][c] = 0; m_age[v][c] = 0;
        end
    end else begin
      for (int v = 0; v < 2; v++)
        for (int c = 0; c < 2; c++) begin
          bit lp;
          int ap;
          lp = m_level[v][c];
          ap = m_age[v][c];
          // Pulse on the edge after acceptance, then (repeat only) at
          // H cycles after that and every R cycles thereafter.
          m_pulse[v][c] = lp && (ap == 0 || (v == 1 && ap >= H && (ap - H) % R == 0));
          if (lp) m_age[v][c] = ap + 1;
          if (m_old[v][c] != lp) begin
            m_run[v][c]++;
            if (m_run[v][c] == D) begin
              m_level[v][c] = m_old[v][c];
              m_run[v][c]   = 0;
              if (m_old[v][c]) m_age[v][c] = 0;
            end
          end else begin
            m_run[v][c] = 0;
          end
          m_old[v][c] = m_new[v][c];
          m_new[v][c] = ~btn_raw[c];
        end
    end
  end

  // ---------------- per-cycle compare -----------------------------------------
  bit         cmp_en   = 1'b1;
  logic [1:0] prev_one = '0;
  logic [1:0] prev_rep = '0;

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int c = 0; c < 2; c++) begin
        check($sformatf("level_one[%0d] @%0d", c, cyc), 32'(level_one[c]), 32'(m_level[0][c]));
        check($sformatf("pulse_one[%0d] @%0d", c, cyc), 32'(pulse_one[c]), 32'(m_pulse[0][c]));
        check($sformatf("level_rep[%0d] @%0d", c, cyc), 32'(level_rep[c]), 32'(m_level[1][c]));
        check($sformatf("pulse_rep[%0d] @%0d", c, cyc), 32'(pulse_rep[c]), 32'(m_pulse[1][c]));
      end
      check($sformatf("pulse_one back-to-back @%0d", cyc), 32'(prev_one & pulse_one), 32'd0);
      check($sformatf("pulse_rep back-to-back @%0d", cyc), 32'(prev_rep & pulse_rep), 32'd0);
      prev_one = pulse_one;
      prev_rep = pulse_rep;
    end
  end

  // ---------------- directed stimulus -----------------------------------------
  int q_one[$];       // edges with pulse_one[0]
  int q_rep[$];       // edges with pulse_rep[0]
  int q_both[$];      // edges with pulse_rep == 2'b11
  int q_both_one[$];  // edges with pulse_one == 2'b11
  bit level_seen;
  int t0;
  int exp_rep[6] = '{7, 17, 22, 27, 32, 37};

  task automatic clear_log();
    q_one.delete(); q_rep.delete(); q_both.delete(); q_both_one.delete();
    level_seen = 1'b0;
  endtask

  // Apply raw before the next edge, hold for n edges, log what comes out.
  task automatic run(input logic [1:0] raw, input int n);
    btn_raw = raw;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (pulse_one[0])        q_one.push_back(cyc);
      if (pulse_rep[0])        q_rep.push_back(cyc);
      if (pulse_rep == 2'b11)  q_both.push_back(cyc);
      if (pulse_one == 2'b11)  q_both_one.push_back(cyc);
      if (|{level_one, level_rep}) level_seen = 1'b1;
    end
  endtask

  function automatic int first_rel(input int q[$], input int base);
    return (q.size() > 0) ? q[0] - base : -1;
  endfunction

  initial begin
    // 1. reset with buttons released, then 50 quiet cycles
    #1 reset_n = 1'b0;
    btn_raw = 2'b11;
    repeat (3) @(negedge clk);
    check("reset level", 32'({level_one, level_rep}), 32'd0);
    check("reset pulse", 32'({pulse_one, pulse_rep}), 32'd0);
    reset_n = 1'b1;
    clear_log();
    run(2'b11, 50);
    check("t1 pulses", 32'(q_one.size() + q_rep.size()), 32'd0);
    check("t1 level",  32'(level_seen), 32'd0);

    // 2. press shorter than the debounce window
    clear_log();
    run(2'b10, 3);
    run(2'b11, 20);
    check("t2 pulses", 32'(q_one.size() + q_rep.size()), 32'd0);
    check("t2 level",  32'(level_seen), 32'd0);

    // 3. 20-cycle press: single-shot pulses once at edge 7; repeat unit also
    //    reaches 17 and 22 before the release is accepted at edge 26
    clear_log();
    t0 = cyc;
    run(2'b10, 20);
    run(2'b11, 30);
    check("t3 one count", 32'(q_one.size()), 32'd1);
    check("t3 one edge",  32'(first_rel(q_one, t0)), 32'd7);
    check("t3 rep count", 32'(q_rep.size()), 32'd3);

    // 4. long hold: release applied before edge 35 is accepted at edge 40,
    //    so the repeat train is 7,17,22,27,32,37 with nothing afterwards
    clear_log();
    t0 = cyc;
    run(2'b10, 34);
    run(2'b11, 36);
    check("t4 rep count", 32'(q_rep.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("t4 rep edge %0d", i),
            32'((q_rep.size() > i) ? q_rep[i] - t0 : -1), 32'(exp_rep[i]));
    check("t4 one count", 32'(q_one.size()), 32'd1);

    // 5. bounce 0,1,0,1 then stable 0: one pulse at edge 7 of the stable run
    clear_log();
    run(2'b10, 1);
    run(2'b11, 1);
    run(2'b10, 1);
    run(2'b11, 1);
    t0 = cyc;
    run(2'b10, 15);
    run(2'b11, 25);
    check("t5 one count", 32'(q_one.size()), 32'd1);
    check("t5 one edge",  32'(first_rel(q_one, t0)), 32'd7);

    // 6. both pressed together, then reset mid-hold while still held
    clear_log();
    t0 = cyc;
    run(2'b00, 12);
    check("t6 both rep edge", 32'(first_rel(q_both, t0)), 32'd7);
    check("t6 both one edge", 32'(first_rel(q_both_one, t0)), 32'd7);
    check("t6 held level", 32'(level_rep), 32'd3);
    #2 reset_n = 1'b0;
    #1;
    check("t6 async reset", 32'({level_one, pulse_one, level_rep, pulse_rep}), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    clear_log();
    t0 = cyc;
    run(2'b00, 10);
    run(2'b11, 25);
    check("t6 post-reset count", 32'(q_both.size()), 32'd1);
    check("t6 post-reset edge",  32'(first_rel(q_both, t0)), 32'd7);

    cmp_en = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
